mem_perf_monitor: RTL



---
 rtl/mem_perf_pkg.sv | 33 +++
 rtl/mem_perf_monitor_if.sv | 21 ++
 rtl/mem_perf_satcnt.sv | 31 +++
 rtl/mem_perf_monitor.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_perf_pkg.sv
// mem_perf_pkg: shared types and constants for the memory performance monitor.
//   state_t - monitor FSM states (idle / request outstanding)
//   lat_t   - 8-bit saturating latency type
//   ERR_*   - bit positions inside the sticky err vector
//   lat_inc - saturating +1 on a latency value
package mem_perf_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef logic [7:0] lat_t;

    localparam int ERR_W        = 6;
    localparam int ERR_HIT_LAT  = 0;
    localparam int ERR_MISS_LAT = 1;
    localparam int ERR_DATA     = 2;
    localparam int ERR_DROP     = 3;
    localparam int ERR_TIMEOUT  = 4;
    localparam int ERR_SPURIOUS = 5;

    function automatic lat_t lat_inc(input lat_t v);
        lat_t r;
        if (v == 8'hFF) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_perf_monitor_if.sv
// mem_perf_monitor_if: the observed cache request/response channel.
//   rd, wr, addr            - request strobes and address
//   stall, done, cache_hit  - memory system handshake / completion info
//   data_out, data_ref      - DUT read data and reference-model read data
//   master modport drives the channel, slave modport observes it.
interface mem_perf_monitor_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic              stall;
    logic              done;
    logic              cache_hit;
    logic [DATA_W-1:0] data_out;
    logic [DATA_W-1:0] data_ref;

    modport master (output rd, wr, addr, stall, done, cache_hit, data_out, data_ref);
    modport slave  (input  rd, wr, addr, stall, done, cache_hit, data_out, data_ref);
endinterface

// File: rtl/mem_perf_satcnt.sv
// mem_perf_satcnt: W-bit counter that increments on inc and sticks at all-ones.
//   clk, rst - clock, async active-high reset
//   clr      - synchronous clear (wins over inc)
//   inc      - count enable
//   cnt      - registered count value
module mem_perf_satcnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_r;

    // Saturating count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {W{1'b0}};
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (inc && (cnt_r != {W{1'b1}})) begin
            cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;
endmodule

// File: rtl/mem_perf_monitor.sv
// mem_perf_monitor: latency / correctness monitor for one cache request channel.
//   clk, rst        - clock, async active-high reset
//   clr             - synchronous clear of counters, flags and state
//   bus             - observed channel (slave modport of mem_perf_monitor_if)
//   busy            - a request is outstanding
//   n_req/n_rep/n_hit/n_cyc - saturating statistics counters
//   last_lat/max_lat        - latest and worst completed latency
//   err, err_addr, fail     - sticky error flags, first-error address, OR of err
// Optional feature macro MEM_PERF_HIST_EN adds hist_sel/hist_cnt and a
// 16-bin latency histogram (bin = min(latency, 15)).
module mem_perf_monitor
    import mem_perf_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int CNT_W        = 32,
    parameter int HIT_MAX_LAT  = 2,
    parameter int MISS_MIN_LAT = 3,
    parameter int MISS_MAX_LAT = 20,
    parameter int TIMEOUT      = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    mem_perf_monitor_if.slave  bus,
`ifdef MEM_PERF_HIST_EN
    input  logic [3:0]         hist_sel,
    output logic [CNT_W-1:0]   hist_cnt,
`endif
    output logic               busy,
    output logic [CNT_W-1:0]   n_req,
    output logic [CNT_W-1:0]   n_rep,
    output logic [CNT_W-1:0]   n_hit,
    output logic [CNT_W-1:0]   n_cyc,
    output logic [7:0]         last_lat,
    output logic [7:0]         max_lat,
    output logic [ERR_W-1:0]   err,
    output logic [ADDR_W-1:0]  err_addr,
    output logic               fail
);
    localparam lat_t HIT_L      = lat_t'(HIT_MAX_LAT);
    localparam lat_t MISS_MIN_L = lat_t'(MISS_MIN_LAT);
    localparam lat_t MISS_MAX_L = lat_t'(MISS_MAX_LAT);
    localparam lat_t TMO_L      = lat_t'(TIMEOUT);

    state_t             state_r, state_next_s;
    lat_t               lat_cnt_r, lat_next_s, lat_inc_s, cmpl_lat_s;
    logic               op_wr_r, op_wr_next_s;
    logic [ADDR_W-1:0]  addr_r, addr_next_s, err_src_s;
    logic               busy_r, fail_r;
    lat_t               last_lat_r, max_lat_r;
    logic [ERR_W-1:0]   err_r, err_set_s, err_next_s;
    logic [ADDR_W-1:0]  err_addr_r;
    logic               accept_s, cmpl_s, cmpl_wr_s, drop_s, tmo_s, spur_s, err_load_s;

    // Next-state, latency tracking and event decode
    always_comb begin
        state_next_s = state_r;
        lat_next_s   = lat_cnt_r;
        op_wr_next_s = op_wr_r;
        addr_next_s  = addr_r;
        lat_inc_s    = lat_inc(lat_cnt_r);
        cmpl_s       = 1'b0;
        cmpl_lat_s   = 8'd0;
        cmpl_wr_s    = 1'b0;
        drop_s       = 1'b0;
        tmo_s        = 1'b0;
        spur_s       = 1'b0;
        accept_s     = (bus.rd | bus.wr) & ~bus.stall;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    // rd & wr together is treated as a write
                    addr_next_s  = bus.addr;
                    op_wr_next_s = bus.wr;
                    lat_next_s   = 8'd0;
                    if (bus.done) begin
                        // completes on its own accept edge: latency 0
                        cmpl_s       = 1'b1;
                        cmpl_wr_s    = bus.wr;
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_WAIT;
                    end
                end else begin
                    spur_s = bus.done;
                end
            end
            ST_WAIT: begin
                if (bus.done) begin
                    cmpl_s       = 1'b1;
                    cmpl_lat_s   = lat_inc_s;
                    cmpl_wr_s    = op_wr_r;
                    state_next_s = ST_IDLE;
                end else begin
                    cmpl_s = 1'b0;
                end
                if (accept_s) begin
                    // old request finishes first; only an accept without done drops it
                    drop_s       = ~bus.done;
                    addr_next_s  = bus.addr;
                    op_wr_next_s = bus.wr;
                    lat_next_s   = 8'd0;
                    state_next_s = ST_WAIT;
                end else if (!bus.done) begin
                    lat_next_s = lat_inc_s;
                    if (lat_inc_s == TMO_L) begin
                        tmo_s        = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        tmo_s = 1'b0;
                    end
                end else begin
                    lat_next_s = 8'd0;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        err_set_s               = {ERR_W{1'b0}};
        err_set_s[ERR_HIT_LAT]  = cmpl_s & bus.cache_hit & (cmpl_lat_s > HIT_L);
        err_set_s[ERR_MISS_LAT] = cmpl_s & ~bus.cache_hit &
                                  ((cmpl_lat_s < MISS_MIN_L) | (cmpl_lat_s > MISS_MAX_L));
        err_set_s[ERR_DATA]     = cmpl_s & ~cmpl_wr_s & (bus.data_out != bus.data_ref);
        err_set_s[ERR_DROP]     = drop_s;
        err_set_s[ERR_TIMEOUT]  = tmo_s;
        err_set_s[ERR_SPURIOUS] = spur_s;
        err_next_s              = err_r | err_set_s;
        err_load_s              = (err_r == {ERR_W{1'b0}}) && (err_set_s != {ERR_W{1'b0}});
        // every event in WAIT concerns the latched request; in IDLE it is the bus address
        err_src_s               = (state_r == ST_WAIT) ? addr_r : bus.addr;
    end

    // State, latency and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            lat_cnt_r  <= 8'd0;
            op_wr_r    <= 1'b0;
            addr_r     <= {ADDR_W{1'b0}};
            busy_r     <= 1'b0;
            last_lat_r <= 8'd0;
            max_lat_r  <= 8'd0;
            err_r      <= {ERR_W{1'b0}};
            err_addr_r <= {ADDR_W{1'b0}};
            fail_r     <= 1'b0;
        end else if (clr) begin
            state_r    <= ST_IDLE;
            lat_cnt_r  <= 8'd0;
            op_wr_r    <= 1'b0;
            addr_r     <= {ADDR_W{1'b0}};
            busy_r     <= 1'b0;
            last_lat_r <= 8'd0;
            max_lat_r  <= 8'd0;
            err_r      <= {ERR_W{1'b0}};
            err_addr_r <= {ADDR_W{1'b0}};
            fail_r     <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            lat_cnt_r <= lat_next_s;
            op_wr_r   <= op_wr_next_s;
            addr_r    <= addr_next_s;
            busy_r    <= (state_next_s == ST_WAIT);
            err_r     <= err_next_s;
            fail_r    <= |err_next_s;
            if (cmpl_s) begin
                last_lat_r <= cmpl_lat_s;
                max_lat_r  <= (cmpl_lat_s > max_lat_r) ? cmpl_lat_s : max_lat_r;
            end else begin
                last_lat_r <= last_lat_r;
                max_lat_r  <= max_lat_r;
            end
            if (err_load_s) begin
                err_addr_r <= err_src_s;
            end else begin
                err_addr_r <= err_addr_r;
            end
        end
    end

    // A drop abandons the one outstanding request, so n_rep catching up to
    // n_req-1 is a single increment.
    mem_perf_satcnt #(.W(CNT_W)) u_n_req (.clk(clk), .rst(rst), .clr(clr), .inc(accept_s), .cnt(n_req));
    mem_perf_satcnt #(.W(CNT_W)) u_n_rep (.clk(clk), .rst(rst), .clr(clr),
                                          .inc(cmpl_s | drop_s | tmo_s), .cnt(n_rep));
    mem_perf_satcnt #(.W(CNT_W)) u_n_hit (.clk(clk), .rst(rst), .clr(clr),
                                          .inc(cmpl_s & bus.cache_hit), .cnt(n_hit));
    mem_perf_satcnt #(.W(CNT_W)) u_n_cyc (.clk(clk), .rst(rst), .clr(clr), .inc(1'b1), .cnt(n_cyc));

`ifdef MEM_PERF_HIST_EN
    logic [3:0]       hist_bin_s;
    logic [CNT_W-1:0] hist_bins_s [16];

    assign hist_bin_s = (cmpl_lat_s > 8'd15) ? 4'd15 : cmpl_lat_s[3:0];

    for (genvar g = 0; g < 16; g++) begin : g_hist
        mem_perf_satcnt #(.W(CNT_W)) u_bin (
            .clk(clk), .rst(rst), .clr(clr),
            .inc(cmpl_s && (hist_bin_s == 4'(g))),
            .cnt(hist_bins_s[g])
        );
    end

    assign hist_cnt = hist_bins_s[hist_sel];
`endif

    assign busy     = busy_r;
    assign last_lat = last_lat_r;
    assign max_lat  = max_lat_r;
    assign err      = err_r;
    assign err_addr = err_addr_r;
    assign fail     = fail_r;
endmodule
